// File: rtl/conv1_k_fetch_if.sv
// ROM read ports and beat stream between conv1_k_fetch and its ROM/consumer.
// master = fetch sequencer side, slave = ROM + convolution datapath side.
interface conv1_k_fetch_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address_a;
    logic [ADDR_W-1:0]   address_b;
    logic [DATA_W-1:0]   q_a;
    logic [DATA_W-1:0]   q_b;
    logic [2*DATA_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    // A beat transfers on a rising edge where out_valid && out_ready; once raised,
    // out_valid holds and out_data stays stable until that transfer happens.
    modport master (
        output address_a, address_b, out_data, out_valid,
        input  q_a, q_b, out_ready
    );

    modport slave (
        input  address_a, address_b, out_data, out_valid,
        output q_a, q_b, out_ready
    );
endinterface

// File: rtl/conv1_k_fetch.sv
// Read sequencer for the conv1 kernel weight ROM: pairs of words packed into 32-bit beats.
// Optional running checksum of accepted beats: define CONV1_FETCH_CHECKSUM_EN.
module conv1_k_fetch #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int FIFO_D = 2
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W-1:0]    pair_cnt_i,
    conv1_k_fetch_if.master      fetch_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_W-1:0]    checksum_o,
    output logic [1:0]           state_o
);
    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = $clog2(FIFO_D + 1);
    localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   rem_q;
    logic                inflight_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic                busy_q;
    logic                done_q;
    logic [2*DATA_W-1:0] mem_q [FIFO_D];
    logic [PW-1:0]       wr_q;
    logic [PW-1:0]       rd_q;
    logic [CW-1:0]       count_q;

    logic                push;
    logic                pop;
    logic                issue;
    logic                start_acc;
    logic [CW:0]         occ;
    logic [CW-1:0]       count_d;
    logic [2*DATA_W-1:0] head_data;

    assign push      = inflight_q;
    assign pop       = (count_q != '0) && fetch_if.out_ready;
    assign start_acc = (state_q == S_IDLE) && start_i;

    // A beat popped this cycle frees its slot in time for a read issued now,
    // which is what lets a 2-deep buffer sustain one beat per cycle.
    always_comb begin
        occ     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue   = (state_q == S_FETCH) && (occ < DEPTH);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Addresses are presented in the issue cycle itself; otherwise the last pair is held.
    assign fetch_if.address_a = issue ? ptr_q : addr_a_q;
    assign fetch_if.address_b = issue ? (ptr_q + ADDR_W'(1)) : addr_b_q;

    assign head_data          = mem_q[rd_q];
    assign fetch_if.out_data  = head_data;
    assign fetch_if.out_valid = (count_q != '0);
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign state_o            = state_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {fetch_if.q_b, fetch_if.q_a};
                wr_q        <= (wr_q == PW'(FIFO_D - 1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) rd_q <= (rd_q == PW'(FIFO_D - 1)) ? '0 : rd_q + PW'(1);
            count_q    <= count_d;
            inflight_q <= issue;
            done_q     <= 1'b0;

            if (issue) begin
                addr_a_q <= ptr_q;
                addr_b_q <= ptr_q + ADDR_W'(1);
                ptr_q    <= ptr_q + ADDR_W'(2);
                rem_q    <= rem_q - ADDR_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ptr_q  <= base_addr_i;
                        rem_q  <= pair_cnt_i;
                        busy_q <= 1'b1;
                        // An empty run passes through DRAIN so done lands 2 cycles after start.
                        state_q <= (pair_cnt_i == '0) ? S_DRAIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (issue && (rem_q == ADDR_W'(1))) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!inflight_q && (count_d == '0)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CONV1_FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q + head_data[DATA_W-1:0] + head_data[2*DATA_W-1:DATA_W];
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif
endmodule
